// File: rtl/intmul_pkg.sv
// Shared constants and latency helper for the 34x43 chunked integer multiplier.
package intmul_pkg;

    localparam int unsigned DSP_WA  = 26;
    localparam int unsigned DSP_WB  = 17;
    localparam int unsigned DSP_WP  = DSP_WA + DSP_WB;

    localparam int unsigned WA_FULL = 34;
    localparam int unsigned WB_FULL = 43;
    localparam int unsigned WC_FULL = WA_FULL + WB_FULL;

    localparam int unsigned CHUNK_A = 17;
    localparam int unsigned CHUNK_B = 26;

    localparam int unsigned SH_A1   = 17;
    localparam int unsigned SH_B1   = 26;
    localparam int unsigned SH_A1B1 = 43;

    function automatic int unsigned calc_lat(
        input int unsigned ff_in,
        input int unsigned ff_mul,
        input int unsigned use_csa,
        input int unsigned ff_csa,
        input int unsigned ff_out
    );
        return ff_in + ff_mul + ((use_csa != 0) ? ff_csa : 0) + ff_out;
    endfunction

endpackage

// File: rtl/intmul_nonstd_bbxab_dsp.sv
// Unsigned 26x17 multiply with an optional output register (one DSP slice).
module dsp_mul26x17
    import intmul_pkg::*;
#(
    parameter int unsigned FF_MUL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DSP_WA-1:0] a,
    input  logic [DSP_WB-1:0] b,
    output logic [DSP_WP-1:0] p
);

    logic [DSP_WP-1:0] prod;

    assign prod = DSP_WP'(a) * DSP_WP'(b);

    if (FF_MUL != 0) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) p <= '0;
            else     p <= prod;
        end
    end else begin : g_comb
        assign p = prod;
    end

endmodule

// File: rtl/intmul_nonstd_bbxab.sv
// Pipelined unsigned multiplier, A split 17/17 and B split 26/17 into four DSP products.
// Define INTMUL_VALID_EN to add in_valid/out_valid tracking through the pipeline.
module intmul_nonstd_bbxab
    import intmul_pkg::*;
#(
    parameter int unsigned LOGA     = 34,
    parameter int unsigned LOGB     = 43,
    parameter int unsigned FF_IN    = 1,
    parameter int unsigned FF_MUL   = 1,
    parameter int unsigned FF_OUT   = 1,
    parameter int unsigned USE_CSA  = 1,
    parameter int unsigned FF_CSA   = 1,
    parameter int unsigned MORE_DSP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LOGA-1:0]      A,
    input  logic [LOGB-1:0]      B,
`ifdef INTMUL_VALID_EN
    input  logic                 in_valid,
    output logic                 out_valid,
`endif
    output logic [LOGA+LOGB-1:0] C
);

    localparam int unsigned LAT = calc_lat(FF_IN, FF_MUL, USE_CSA, FF_CSA, FF_OUT);

    logic [WA_FULL-1:0] a_ext, a_q;
    logic [WB_FULL-1:0] b_ext, b_q;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[LOGA-1:0] = A;
        b_ext[LOGB-1:0] = B;
    end

    if (FF_IN != 0) begin : g_in_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= a_ext;
                b_q <= b_ext;
            end
        end
    end else begin : g_in_comb
        assign a_q = a_ext;
        assign b_q = b_ext;
    end

    logic [CHUNK_A-1:0] a0, a1;
    logic [CHUNK_B-1:0] b0;
    logic [DSP_WB-1:0]  b1;
    logic [DSP_WA-1:0]  a0_w, a1_w;

    assign a0   = a_q[CHUNK_A-1:0];
    assign a1   = a_q[WA_FULL-1:CHUNK_A];
    assign b0   = b_q[CHUNK_B-1:0];
    assign b1   = b_q[WB_FULL-1:CHUNK_B];
    assign a0_w = {{(DSP_WA-CHUNK_A){1'b0}}, a0};
    assign a1_w = {{(DSP_WA-CHUNK_A){1'b0}}, a1};

    logic [DSP_WP-1:0] p00, p10, p01, p11;

    dsp_mul26x17 #(.FF_MUL(FF_MUL)) u_p00 (.clk(clk), .rst(rst), .a(b0),   .b(a0), .p(p00));
    dsp_mul26x17 #(.FF_MUL(FF_MUL)) u_p10 (.clk(clk), .rst(rst), .a(b0),   .b(a1), .p(p10));
    dsp_mul26x17 #(.FF_MUL(FF_MUL)) u_p01 (.clk(clk), .rst(rst), .a(a0_w), .b(b1), .p(p01));
    dsp_mul26x17 #(.FF_MUL(FF_MUL)) u_p11 (.clk(clk), .rst(rst), .a(a1_w), .b(b1), .p(p11));

    logic [WC_FULL-1:0] t0, t1, t2, t3;

    assign t0 = WC_FULL'(p00);
    assign t1 = WC_FULL'(p10) << SH_A1;
    assign t2 = WC_FULL'(p01) << SH_B1;
    assign t3 = WC_FULL'(p11) << SH_A1B1;

    // Both branches hand two operands to one final carry-propagate adder.
    logic [WC_FULL-1:0] x_op, y_op;

    if (USE_CSA != 0) begin : g_csa
        logic [WC_FULL-1:0] s1, c1, s2, c2;

        always_comb begin
            s1 = t0 ^ t1 ^ t2;
            c1 = ((t0 & t1) | (t0 & t2) | (t1 & t2)) << 1;
            s2 = s1 ^ c1 ^ t3;
            c2 = ((s1 & c1) | (s1 & t3) | (c1 & t3)) << 1;
        end

        if (FF_CSA != 0) begin : g_csa_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    x_op <= '0;
                    y_op <= '0;
                end else begin
                    x_op <= s2;
                    y_op <= c2;
                end
            end
        end else begin : g_csa_comb
            assign x_op = s2;
            assign y_op = c2;
        end
    end else begin : g_tree
        assign x_op = t0 + t1;
        assign y_op = t2 + t3;
    end

    logic [WC_FULL-1:0] sum, sum_q;

    if (MORE_DSP != 0) begin : g_cpa_dsp
        (* use_dsp = "yes" *) logic [WC_FULL-1:0] cpa;
        assign cpa = x_op + y_op;
        assign sum = cpa;
    end else begin : g_cpa_fabric
        assign sum = x_op + y_op;
    end

    if (FF_OUT != 0) begin : g_out_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sum_q <= '0;
            else     sum_q <= sum;
        end
    end else begin : g_out_comb
        assign sum_q = sum;
    end

    assign C = sum_q[LOGA+LOGB-1:0];

`ifdef INTMUL_VALID_EN
    if (LAT > 0) begin : g_vld
        logic [LAT-1:0] vsr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vsr <= '0;
            end else begin
                vsr[0] <= in_valid;
                for (int unsigned i = 1; i < LAT; i++) vsr[i] <= vsr[i-1];
            end
        end

        assign out_valid = vsr[LAT-1];
    end else begin : g_vld_comb
        assign out_valid = in_valid;
    end
`endif

endmodule

// File: tb/tb_intmul_nonstd_bbxab.sv
// Directed and random checks of intmul_nonstd_bbxab: default build (LAT=4) and a tree variant (LAT=2).
module tb_intmul_nonstd_bbxab;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] a;
    logic [42:0] b;
    logic [76:0] c1, c2;
    logic        in_valid;
`ifdef INTMUL_VALID_EN
    logic        ov1, ov2;
`endif

    int checks = 0;
    int errors = 0;

    logic [76:0] pipe  [0:3];
    logic        vpipe [0:3];

    always #5 clk = ~clk;

    intmul_nonstd_bbxab dut (
        .clk(clk), .rst(rst), .A(a), .B(b),
`ifdef INTMUL_VALID_EN
        .in_valid(in_valid), .out_valid(ov1),
`endif
        .C(c1)
    );

    intmul_nonstd_bbxab #(
        .FF_IN(0), .FF_MUL(1), .FF_OUT(1), .USE_CSA(0), .FF_CSA(1), .MORE_DSP(0)
    ) dut2 (
        .clk(clk), .rst(rst), .A(a), .B(b),
`ifdef INTMUL_VALID_EN
        .in_valid(in_valid), .out_valid(ov2),
`endif
        .C(c2)
    );

    typedef struct {
        logic [33:0] a;
        logic [42:0] b;
        logic [76:0] e;
        logic        v;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [76:0] act, input logic [76:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            pipe[i]  = '0;
            vpipe[i] = 1'b0;
        end
    endtask

    // Sample the results due this cycle, then present the next operand pair.
    task automatic step(input logic [33:0] na, input logic [42:0] nb,
                        input logic [76:0] ne, input logic nv);
        @(posedge clk);
        #1;
        chk("c_lat4", c1, pipe[3]);
        chk("c_lat2", c2, pipe[1]);
`ifdef INTMUL_VALID_EN
        chk("vld_lat4", 77'(ov1), 77'(vpipe[3]));
        chk("vld_lat2", 77'(ov2), 77'(vpipe[1]));
`endif
        for (int i = 3; i > 0; i--) begin
            pipe[i]  = pipe[i-1];
            vpipe[i] = vpipe[i-1];
        end
        pipe[0]  = ne;
        vpipe[0] = nv;
        a        = na;
        b        = nb;
        in_valid = nv;
    endtask

    initial begin
        logic [63:0] r;
        logic [33:0] ra;
        logic [42:0] rb;

        tbl[0] = '{34'h3_FFFF_FFFF, 43'h7FF_FFFF_FFFF,
                   {77{1'b1}} - (77'd1 << 43) - (77'd1 << 34) + 77'd2, 1'b1};
        tbl[1] = '{34'h0_0002_0000, 43'h000_0400_0000, 77'd1 << 43, 1'b0};
        tbl[2] = '{34'h0_0001_FFFF, 43'h000_03FF_FFFF,
                   (77'd1 << 43) - (77'd1 << 26) - (77'd1 << 17) + 77'd1, 1'b1};
        tbl[3] = '{34'h0, 43'h5A5_A5A5_A5A5, 77'd0, 1'b1};
        tbl[4] = '{34'h1, 43'h5A5_A5A5_A5A5, 77'h5A5_A5A5_A5A5, 1'b0};
        tbl[5] = '{34'h2_AAAA_AAAA, 43'h3, 77'h7_FFFF_FFFE, 1'b1};
        tbl[6] = '{34'h3, 43'h7FF_FFFF_FFFF, (77'd3 << 43) - 77'd3, 1'b1};
        tbl[7] = '{34'h3_FFFF_FFFF, 43'h1, (77'd1 << 34) - 77'd1, 1'b0};
        tbl[8] = '{34'h1, 43'h7FF_FFFF_FFFF, (77'd1 << 43) - 77'd1, 1'b1};

        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        clear_model();

        #3;
        chk("reset_c_lat4", c1, 77'd0);
        chk("reset_c_lat2", c2, 77'd0);
        chk("lat_param_4", 77'(dut.LAT), 77'd4);
        chk("lat_param_2", 77'(dut2.LAT), 77'd2);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) step(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].v);
        repeat (4) step('0, '0, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            r  = {$urandom(), $urandom()};
            ra = r[33:0];
            r  = {$urandom(), $urandom()};
            rb = r[42:0];
            step(ra, rb, 77'(ra) * 77'(rb), r[63]);
        end

        // Three products in flight when reset hits between edges.
        step(34'h1_2345_6789, 43'h123_4567_89AB, 77'h1_2345_6789 * 77'h123_4567_89AB, 1'b1);
        step(34'h3_FFFF_FFFF, 43'h7FF_FFFF_FFFF, tbl[0].e, 1'b1);
        step(34'h0_0002_0000, 43'h000_0400_0000, tbl[1].e, 1'b1);
        #2;
        rst = 1'b1;
        a = '0;
        b = '0;
        in_valid = 1'b0;
        #1;
        chk("midrst_c_lat4", c1, 77'd0);
        chk("midrst_c_lat2", c2, 77'd0);
`ifdef INTMUL_VALID_EN
        chk("midrst_vld", 77'(ov1), 77'd0);
`endif
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(34'h0_0001_FFFF, 43'h000_03FF_FFFF, tbl[2].e, 1'b1);
        repeat (5) step('0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intmul_nonstd_bbxab.md
Name: intmul_nonstd_bbxab

Overview:
- Fully pipelined unsigned integer multiplier, C = A*B, for a LOGA x LOGB product (default 34x43).
- Both operands are split into DSP-sized chunks. A is split into two 17-bit chunks ("BB"). B is split into one 26-bit and one 17-bit chunk ("AB").
- Each partial product therefore fits an unsigned 26x17 DSP multiplier.
- Serves as the integer-multiply core of the modular-multiplier datapath.
- Accepts one new operand pair every cycle (throughput 1).

Parameters:
- LOGA, 34: width of A; must be 1..34; internally zero-extended to 34.
- LOGB, 43: width of B; must be 1..43; internally zero-extended to 43.
- FF_IN, 1: 0/1, register the A and B inputs.
- FF_MUL, 1: 0/1, register the DSP partial-product outputs.
- FF_OUT, 1: 0/1, register C.
- USE_CSA, 1: 1 = reduce partial products to a sum/carry pair before the final adder; 0 = plain adder tree.
- FF_CSA, 1: 0/1, register the CSA sum/carry; ignored when USE_CSA=0.
- MORE_DSP, 1: 1 = tag the final carry-propagate adder for DSP mapping; 0 = fabric adder. No functional effect.
- LAT (localparam, must be hierarchically readable) = FF_IN + FF_MUL + (USE_CSA ? FF_CSA : 0) + FF_OUT.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- A, input, LOGA: multiplicand.
- B, input, LOGB: multiplier.
- C, output, LOGA+LOGB: product A*B.

Behaviour:
- Decomposition:
  - A = a1·2^17 + a0, with a0 and a1 17 bits each.
  - B = b1·2^26 + b0, with b0 26 bits and b1 17 bits.
  - Partial products: p00=a0·b0 (43b), p10=a1·b0 (43b), p01=a0·b1 (34b), p11=a1·b1 (34b).
  - C = p00 + p10<<17 + p01<<26 + p11<<43, truncated to LOGA+LOGB bits. Truncation is exact, since the true product fits.
- Result timing: operands presented before rising edge k appear on C after edge k+LAT-1. Equivalently, C is valid LAT full clock periods after the inputs are applied.
- LAT=0 gives a purely combinational C.
- Throughput: one new pair per cycle. No stalls, no handshake.
- USE_CSA=1: the four shifted partial products are compressed (3:2/4:2) into sum and carry. A single carry-propagate adder produces C. FF_CSA optionally registers between compression and the adder.
- USE_CSA=0: a binary adder tree directly produces C.
- Reset:
  - rst asynchronously clears every pipeline register to 0. C = 0 while rst is high whenever FF_OUT=1.
  - After deassertion, C shows products of the operands applied since release. Zero-valued bubbles clear out as the pipeline refills.
  - Reset mid-operation discards in-flight products.
- All parameter combinations must produce bit-identical results, differing only in latency.

Optional Feature:
- Macro INTMUL_VALID_EN.
- Defined:
  - Adds input in_valid (1 bit) and output out_valid (1 bit).
  - in_valid is delayed through a LAT-stage shift register, cleared by rst.
  - out_valid=1 marks C as a valid product. The datapath is unchanged.
- Undefined: no valid ports; C is free-running.

Decomposition:
- Package intmul_pkg:
  - DSP_WA=26, DSP_WB=17.
  - Chunk widths and shift constants (17, 26, 43).
  - Function computing LAT from the FF_* and USE_CSA parameters.
- One sub-module, dsp_mul26x17: unsigned 26x17 multiply with parameterised output register (FF_MUL). It is instantiated four times.
- CSA and adder logic stay inline.

Test Plan:
- Max operands, all FF=1, USE_CSA=1: A=2^34-1, B=2^43-1, then zeros for LAT cycles -> C = 2^77 - 2^43 - 2^34 + 1 exactly after LAT periods.
- Chunk-boundary pair A=2^17, B=2^26 -> C=2^43. Also A=2^17-1, B=2^26-1 -> C=(2^17-1)(2^26-1).
- Zero and identity: A=0, B=0x5A5A5A5A5A5 -> C=0; A=1, same B -> C=0x5A5A5A5A5A5.
- Streaming: 10,000 random back-to-back pairs. Each C matches A·B from exactly LAT cycles earlier. Sweep all 2^6 combinations of FF_IN, FF_MUL, FF_OUT, USE_CSA, FF_CSA, MORE_DSP.
- Reset mid-stream: assert rst while 3 products are in flight -> C=0 immediately (FF_OUT=1). The first post-reset product appears after LAT cycles with no stale data.
- With INTMUL_VALID_EN: in_valid pattern 1,0,1,1 -> the same out_valid pattern LAT cycles later, aligned with the matching C.
